// File: rtl/signal_change_recorder_pkg.sv
// Shared definitions for the signal change recorder: record field layout and FIFO op codes.
// The field offsets are the same ones the software-side decoder uses to unpack records.
package signal_change_recorder_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_t;

  localparam int VALUE_LSB = 0;

  function automatic int time_lsb(input int width);
    return VALUE_LSB + width;
  endfunction

  function automatic int lost_bit(input int width, input int ts_w);
    return time_lsb(width) + ts_w;
  endfunction

  function automatic int rec_w(input int width, input int ts_w);
    return lost_bit(width, ts_w) + 1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO; storage is unreset and the head output reads zero while empty.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module trace_fifo
  import signal_change_recorder_pkg::*;
#(
  parameter int W     = 25,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         push_ok, pop_ok;
  fifo_op_t     op;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign op      = fifo_op_t'({push_ok, pop_ok});
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop_ok)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
      case (op)
        OP_PUSH: count <= count + {{AW{1'b0}}, 1'b1};
        OP_POP:  count <= count - {{AW{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/signal_change_recorder.sv
// Records every change of a probe bus, with a cycle timestamp, into a show-ahead FIFO.
// Raising en records a snapshot; records lost to a full FIFO are flagged on the next one stored.
module signal_change_recorder
  import signal_change_recorder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  probe,
  input  logic              clr_dropped,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WIDTH-1:0]  rd_value,
  output logic [TS_W-1:0]   rd_time,
  output logic              rd_lost,
  output logic [CW-1:0]     count,
  output logic              dropped
);

  localparam int RW   = rec_w(WIDTH, TS_W);
  localparam int TLSB = time_lsb(WIDTH);
  localparam int LBIT = lost_bit(WIDTH, TS_W);

  logic [TS_W-1:0]  ts;
  logic [WIDTH-1:0] probe_p1;
  logic             en_p1;
  logic             lost_pending;
  logic             push_req, drop;
  logic             full, empty;
  logic [RW-1:0]    rec_in, rec_out;

  assign push_req = en && ((probe != probe_p1) || !en_p1);
  // full implies a valid head, so rd_ready alone decides whether the slot frees up
  assign drop     = push_req && full && !rd_ready;

  always_comb begin
    rec_in                         = '0;
    rec_in[VALUE_LSB +: WIDTH]     = probe;
    rec_in[TLSB +: TS_W]           = ts;
    rec_in[LBIT]                   = lost_pending;
  end

  trace_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (rd_ready),
    .din   (rec_in),
    .dout  (rec_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign rd_valid = !empty;
  assign rd_value = rec_out[VALUE_LSB +: WIDTH];
  assign rd_time  = rec_out[TLSB +: TS_W];
  assign rd_lost  = rec_out[LBIT];

  // p1 stage: previous-cycle probe/enable and record bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts           <= '0;
      probe_p1     <= '0;
      en_p1        <= 1'b0;
      lost_pending <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      if (en) ts <= ts + TS_W'(1);
      probe_p1 <= probe;
      en_p1    <= en;
      if (drop)          lost_pending <= 1'b1;
      else if (push_req) lost_pending <= 1'b0;
      if (drop)             dropped <= 1'b1;
      else if (clr_dropped) dropped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_signal_change_recorder.sv
// Scoreboard bench: a queue-based reference model predicts records, a negedge monitor checks them.
// TS_W is 4 so timestamp wrap is exercised throughout.
module tb_signal_change_recorder;

  localparam int WIDTH = 8;
  localparam int TS_W  = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] probe = '0;
  logic             clr_dropped = 1'b0;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [WIDTH-1:0] rd_value;
  logic [TS_W-1:0]  rd_time;
  logic             rd_lost;
  logic [CW-1:0]    count;
  logic             dropped;

  signal_change_recorder #(.WIDTH(WIDTH), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .probe       (probe),
    .clr_dropped (clr_dropped),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_value    (rd_value),
    .rd_time     (rd_time),
    .rd_lost     (rd_lost),
    .count       (count),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] v;
    logic [TS_W-1:0]  t;
    logic             l;
  } rec_t;

  rec_t expq[$];

  // reference model state
  int               mcnt;
  int               mts;
  logic [WIDTH-1:0] mprev;
  logic             men_q;
  logic             mlost;
  logic             mdropped;

  // expectations for what the DUT shows during the current cycle
  int   exp_cnt;
  logic exp_dropped;
  logic in_rst;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    expq.delete();
    mcnt = 0; mts = 0; mprev = '0; men_q = 1'b0; mlost = 1'b0; mdropped = 1'b0;
    exp_cnt = 0; exp_dropped = 1'b0;
  endtask

  task automatic model_cycle();
    logic pop, req, acc, drp;
    rec_t r;
    exp_cnt     = mcnt;
    exp_dropped = mdropped;
    pop = rd_ready && (mcnt > 0);
    req = en && ((probe != mprev) || !men_q);
    acc = req && ((mcnt < DEPTH) || pop);
    drp = req && !acc;
    if (acc) begin
      r.v = probe; r.t = TS_W'(mts); r.l = mlost;
      expq.push_back(r);
      mlost = 1'b0;
    end
    if (drp) mlost = 1'b1;
    mcnt = mcnt + (acc ? 1 : 0) - (pop ? 1 : 0);
    if (drp) mdropped = 1'b1;
    else if (clr_dropped) mdropped = 1'b0;
    if (en) mts = (mts + 1) % (1 << TS_W);
    mprev = probe;
    men_q = en;
  endtask

  task automatic step(input logic e, input logic [WIDTH-1:0] p, input logic r, input logic c);
    @(posedge clk); #1;
    rst_n = 1'b1; in_rst = 1'b0;
    en = e; probe = p; rd_ready = r; clr_dropped = c;
    model_cycle();
  endtask

  task automatic reset_for(input int n, input logic e, input logic [WIDTH-1:0] p);
    @(posedge clk); #1;
    rst_n = 1'b0; in_rst = 1'b1;
    en = e; probe = p; rd_ready = 1'b0; clr_dropped = 1'b0;
    model_reset();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    chk("count", 32'(count), 32'(exp_cnt));
    chk("dropped", 32'(dropped), 32'(exp_dropped));
    chk("rd_valid", 32'(rd_valid), 32'(exp_cnt != 0));
    if (in_rst) begin
      chk("rst_value", 32'(rd_value), 32'h0);
      chk("rst_time", 32'(rd_time), 32'h0);
      chk("rst_lost", 32'(rd_lost), 32'h0);
    end else if (exp_cnt != 0) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL scoreboard: queue empty with %0d expected records", exp_cnt);
      end else begin
        chk("rd_value", 32'(rd_value), 32'(expq[0].v));
        chk("rd_time", 32'(rd_time), 32'(expq[0].t));
        chk("rd_lost", 32'(rd_lost), 32'(expq[0].l));
        if (rd_ready) void'(expq.pop_front());
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] p;
    in_rst = 1'b1;
    model_reset();

    // snapshot right after reset, then nothing while probe is static
    reset_for(3, 1'b1, 8'h00);
    repeat (6) step(1'b1, 8'h00, 1'b0, 1'b0);

    // two changes read back as they arrive
    step(1'b1, 8'h01, 1'b1, 1'b0);
    repeat (3) step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b1, 8'h03, 1'b1, 1'b0);
    repeat (3) step(1'b1, 8'h03, 1'b1, 1'b0);

    // overflow: ten changes with no reader, then drain and two more changes
    p = 8'h10;
    repeat (10) begin p = p + 8'h01; step(1'b1, p, 1'b0, 1'b0); end
    repeat (2) step(1'b1, p, 1'b0, 1'b0);
    repeat (10) step(1'b1, p, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b1, 8'h56, 1'b0, 1'b0);
    repeat (4) step(1'b1, 8'h56, 1'b1, 1'b0);

    // full FIFO with change and read in the same cycle: no drop
    p = 8'h20;
    repeat (8) begin p = p + 8'h01; step(1'b1, p, 1'b0, 1'b0); end
    step(1'b1, 8'hA0, 1'b1, 1'b0);
    step(1'b1, 8'hA1, 1'b1, 1'b0);
    repeat (10) step(1'b1, 8'hA1, 1'b1, 1'b0);

    // enable off while the probe toggles, then snapshot on re-enable
    for (int i = 0; i < 20; i++) step(1'b0, 8'(i * 7), 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    p = 8'h30;
    repeat (4) begin p = p + 8'h01; step(1'b1, p, 1'b0, 1'b0); end
    repeat (2) step(1'b1, p, 1'b1, 1'b0);

    // reset while records are still waiting
    reset_for(2, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // randomized traffic, including full/drop and clear collisions
    for (int i = 0; i < 3000; i++) begin
      logic e, r, c;
      logic [WIDTH-1:0] pv;
      e  = ($urandom_range(0, 9) != 0);
      pv = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      r  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 15) == 0);
      if (i > 1500 && i < 2000) r = ($urandom_range(0, 3) != 0);
      step(e, pv, r, c);
      if (i == 2500) reset_for(1, 1'b1, pv);
    end
    repeat (12) step(1'b1, probe, 1'b1, 1'b0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
